// File: rtl/onehot_code_encoder_pkg.sv
// Shared definitions for the one-hot select return path encoder.
// States, legal one-hot patterns with their codes, and pattern helpers.
package onehot_code_encoder_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SETTLE  = 3'd1;
   localparam logic [2:0] ST_EMIT    = 3'd2;
   localparam logic [2:0] ST_RELEASE = 3'd3;
   localparam logic [2:0] ST_ERROR   = 3'd4;

   localparam logic [3:0] OH_C0 = 4'b1000;
   localparam logic [3:0] OH_C1 = 4'b0001;
   localparam logic [3:0] OH_C2 = 4'b0010;
   localparam logic [3:0] OH_C3 = 4'b0100;

   localparam logic [1:0] CODE_C0 = 2'b00;
   localparam logic [1:0] CODE_C1 = 2'b01;
   localparam logic [1:0] CODE_C2 = 2'b10;
   localparam logic [1:0] CODE_C3 = 2'b11;

   // Non-zero with more than one bit set.
   function automatic logic is_illegal(input logic [3:0] p);
      return (p != 4'b0000) && ((p & (p - 4'd1)) != 4'b0000);
   endfunction

   function automatic logic [1:0] encode(input logic [3:0] p);
      logic [1:0] c;
      c = CODE_C0;
      case (p)
         OH_C0:   c = CODE_C0;
         OH_C1:   c = CODE_C1;
         OH_C2:   c = CODE_C2;
         OH_C3:   c = CODE_C3;
         default: c = CODE_C0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/onehot_code_encoder_stable_filter.sv
// Sample register and run-length counter for the select lines.
// ONEHOT_ENC_SYNC_EN adds a 2-flop synchronizer in front of the sample.
module stable_filter #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] onehot_i,
   input  logic       load_i,
   input  logic       inc_i,
   input  logic       clr_i,
   output logic [3:0] s_o,
   output logic       same_o,
   output logic       stable_o,
   output logic       zero_stable_o
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [3:0]    s;
   logic [3:0]    ref_q, ref_d;
   logic [CW-1:0] cnt_q, cnt_d;

`ifdef ONEHOT_ENC_SYNC_EN
   logic [3:0] sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q <= 4'b0000;
         sync2_q <= 4'b0000;
      end else begin
         sync1_q <= onehot_i;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = onehot_i;
`endif

   always_comb begin
      ref_d = ref_q;
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         ref_d = s;
         cnt_d = CW'(1);
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ref_q <= 4'b0000;
         cnt_q <= '0;
      end else begin
         ref_q <= ref_d;
         cnt_q <= cnt_d;
      end
   end

   assign s_o    = s;
   assign same_o = (s == ref_q);
   assign stable_o = same_o && (cnt_q == CNT_MAX);
   // True on the edge that completes a debounced release.
   assign zero_stable_o = (s == 4'b0000) && (cnt_q == CNT_LAST);

endmodule

// File: rtl/onehot_code_encoder.sv
// Debounces a 4-line one-hot select bus and returns its 2-bit code.
// Optional input synchronizer: define ONEHOT_ENC_SYNC_EN.
module onehot_code_encoder
   import onehot_code_encoder_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] onehot_in,
   input  logic       ready,
   output logic [1:0] code_out,
   output logic       valid,
   output logic       error
);

   logic [2:0] state_q, state_d;
   logic [1:0] code_q, code_d;
   logic       err_q, err_d;
   logic       load, inc, clr;
   logic [3:0] s;
   logic       same, stable, zero_stable;

   stable_filter #(
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .clk          (clk),
      .rst_n        (rst_n),
      .onehot_i     (onehot_in),
      .load_i       (load),
      .inc_i        (inc),
      .clr_i        (clr),
      .s_o          (s),
      .same_o       (same),
      .stable_o     (stable),
      .zero_stable_o(zero_stable)
   );

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      err_d   = err_q;
      load    = 1'b0;
      inc     = 1'b0;
      clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s != 4'b0000) begin
               load    = 1'b1;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!same) begin
               if (s == 4'b0000) state_d = ST_IDLE;
               else              load    = 1'b1;
            end else if (stable) begin
               clr = 1'b1;
               if (is_illegal(s)) begin
                  err_d   = 1'b1;
                  state_d = ST_ERROR;
               end else begin
                  code_d  = encode(s);
                  state_d = ST_EMIT;
               end
            end else begin
               inc = 1'b1;
            end
         end
         ST_EMIT: begin
            if (ready) begin
               clr     = 1'b1;
               state_d = ST_RELEASE;
            end
         end
         ST_RELEASE, ST_ERROR: begin
            if (s != 4'b0000) begin
               clr = 1'b1;
            end else if (zero_stable) begin
               clr     = 1'b1;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end else begin
               inc = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         code_q  <= 2'b00;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         err_q   <= err_d;
      end
   end

   assign code_out = code_q;
   assign valid    = (state_q == ST_EMIT);
   assign error    = err_q;

endmodule
